// File: rtl/pong_pkg.sv
// Shared types and geometry presets for the pong raster timing path.
// Presets give the active/porch/sync split for each supported display mode.
package pong_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  typedef struct packed {
    int h_active;
    int h_front;
    int h_sync;
    int h_back;
    int v_active;
    int v_front;
    int v_sync;
    int v_back;
  } geom_t;

  localparam geom_t GLCD_128x64 = '{h_active: 128, h_front: 1,  h_sync: 1,  h_back: 0,
                                    v_active: 64,  v_front: 0,  v_sync: 1,  v_back: 0};
  localparam geom_t VGAX_120x60 = '{h_active: 120, h_front: 2,  h_sync: 4,  h_back: 2,
                                    v_active: 60,  v_front: 1,  v_sync: 2,  v_back: 1};
  localparam geom_t HALF_320x240 = '{h_active: 320, h_front: 8,  h_sync: 48, h_back: 24,
                                     v_active: 240, v_front: 5,  v_sync: 2,  v_back: 15};
  localparam geom_t VGA_640x480 = '{h_active: 640, h_front: 16, h_sync: 96, h_back: 48,
                                    v_active: 480, v_front: 10, v_sync: 2,  v_back: 33};

  // Bits needed to hold a counter running 0..n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int geom_h_total(input geom_t g);
    return g.h_active + g.h_front + g.h_sync + g.h_back;
  endfunction

  function automatic int geom_v_total(input geom_t g);
    return g.v_active + g.v_front + g.v_sync + g.v_back;
  endfunction

endpackage

// File: rtl/pong_pix_div.sv
// Pixel-rate divider: counts 0..PIX_DIV-1 and strobes on the last count.
// Clear forces the count to zero and suppresses the strobe.
module pong_pix_div
  import pong_pkg::*;
#(
  parameter int PIX_DIV = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clr,
  output logic o_pix_en
);

  localparam int DIV_W = cnt_width(PIX_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);

  generate
    if (PIX_DIV < 1) begin : g_bad_div
      $error("pong_pix_div: PIX_DIV must be at least 1");
    end
  endgenerate

  logic [DIV_W-1:0] r_div;
  logic             w_last;

  assign w_last = (r_div == DIV_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_div <= '0;
    end else if (i_clr || w_last) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + DIV_W'(1);
    end
  end

  assign o_pix_en = !i_clr && w_last;

endmodule

// File: rtl/pong_scan_timer.sv
// Raster scan/timing generator: pixel divider, x/y scan, sync/blank decode and
// frame counting; stopping always completes the current frame first.
module pong_scan_timer
  import pong_pkg::*;
#(
  parameter int   H_ACTIVE = 128,
  parameter int   H_FRONT  = 1,
  parameter int   H_SYNC   = 1,
  parameter int   H_BACK   = 0,
  parameter int   V_ACTIVE = 64,
  parameter int   V_FRONT  = 0,
  parameter int   V_SYNC   = 1,
  parameter int   V_BACK   = 0,
  parameter int   PIX_DIV  = 2,
  parameter logic HS_POL   = 1'b1,
  parameter logic VS_POL   = 1'b1,
  parameter int   X_W      = 9,
  parameter int   Y_W      = 9,
  parameter int   FCNT_W   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  output logic              pix_en,
  output logic              p_tick,
  output logic [X_W-1:0]    x,
  output logic [Y_W-1:0]    y,
  output logic              hsync,
  output logic              vsync,
  output logic              video_on,
  output logic              line_start,
  output logic              frame_start,
  output logic [FCNT_W-1:0] frame_cnt,
  output logic              running
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  generate
    if (H_TOTAL > (1 << X_W)) begin : g_bad_xw
      $error("pong_scan_timer: H_TOTAL does not fit in X_W bits");
    end
    if (V_TOTAL > (1 << Y_W)) begin : g_bad_yw
      $error("pong_scan_timer: V_TOTAL does not fit in Y_W bits");
    end
  endgenerate

  localparam logic [X_W-1:0] X_LAST = X_W'(H_TOTAL - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(V_TOTAL - 1);

  // Window bounds carry one spare bit so a sync ending exactly at 2**X_W cannot wrap.
  localparam int XE_W = X_W + 1;
  localparam int YE_W = Y_W + 1;
  localparam logic [XE_W-1:0] X_ACT  = XE_W'(H_ACTIVE);
  localparam logic [XE_W-1:0] HS_BEG = XE_W'(H_ACTIVE + H_FRONT);
  localparam logic [XE_W-1:0] HS_END = XE_W'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [YE_W-1:0] Y_ACT  = YE_W'(V_ACTIVE);
  localparam logic [YE_W-1:0] VS_BEG = YE_W'(V_ACTIVE + V_FRONT);
  localparam logic [YE_W-1:0] VS_END = YE_W'(V_ACTIVE + V_FRONT + V_SYNC);

  state_e              r_state;
  state_e              w_state_next;
  logic [X_W-1:0]      r_x;
  logic [Y_W-1:0]      r_y;
  logic [FCNT_W-1:0]   r_frame_cnt;
  logic                w_idle;
  logic                w_pix_en;
  logic                w_x_last;
  logic                w_y_last;
  logic                w_frame_end;
  logic [XE_W-1:0]     w_x_ext;
  logic [YE_W-1:0]     w_y_ext;
  logic                w_hs_win;
  logic                w_vs_win;
  logic                w_video_on;

  assign w_idle = (r_state == IDLE);

  pong_pix_div #(
    .PIX_DIV (PIX_DIV)
  ) u_pix_div (
    .clk      (clk),
    .reset    (reset),
    .i_clr    (w_idle),
    .o_pix_en (w_pix_en)
  );

  assign w_x_last    = (r_x == X_LAST);
  assign w_y_last    = (r_y == Y_LAST);
  assign w_frame_end = w_pix_en && w_x_last && w_y_last;

  // Dropping enable never cuts a frame short: only the last pixel may return to IDLE.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (enable) begin
          w_state_next = RUN;
        end
      end
      RUN, DRAIN: begin
        if (enable) begin
          w_state_next = RUN;
        end else if (w_frame_end) begin
          w_state_next = IDLE;
        end else begin
          w_state_next = DRAIN;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_x <= '0;
      r_y <= '0;
    end else if (w_idle) begin
      r_x <= '0;
      r_y <= '0;
    end else if (w_pix_en) begin
      if (w_x_last) begin
        r_x <= '0;
        r_y <= w_y_last ? '0 : r_y + Y_W'(1);
      end else begin
        r_x <= r_x + X_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_frame_cnt <= '0;
    end else if (w_frame_end) begin
      r_frame_cnt <= r_frame_cnt + FCNT_W'(1);
    end
  end

  assign w_x_ext    = {1'b0, r_x};
  assign w_y_ext    = {1'b0, r_y};
  assign w_hs_win   = !w_idle && (w_x_ext >= HS_BEG) && (w_x_ext < HS_END);
  assign w_vs_win   = !w_idle && (w_y_ext >= VS_BEG) && (w_y_ext < VS_END);
  assign w_video_on = !w_idle && (w_x_ext < X_ACT) && (w_y_ext < Y_ACT);

  assign pix_en      = w_pix_en;
  assign p_tick      = w_pix_en && w_video_on;
  assign x           = r_x;
  assign y           = r_y;
  assign hsync       = w_hs_win ? HS_POL : ~HS_POL;
  assign vsync       = w_vs_win ? VS_POL : ~VS_POL;
  assign video_on    = w_video_on;
  assign line_start  = w_pix_en && (r_x == '0);
  assign frame_start = w_pix_en && (r_x == '0) && (r_y == '0);
  assign frame_cnt   = r_frame_cnt;
  assign running     = !w_idle;

endmodule
